decoder_2: RTL and testbench
============================

DECODER_2 -- requirements
Module: decoder_2

Interface
REQ-001 Parameter ADDR_WIDTH, default 7, wordline address width.
REQ-002 Parameter WL_COUNT, default 128, wordline count; SHALL equal 2**ADDR_WIDTH.
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1, reset; synchronous, active-high.
REQ-005 Port address_1, input, ADDR_WIDTH, read port 1 and write row address.
REQ-006 Port address_2, input, ADDR_WIDTH, read port 2 row address.
REQ-007 Port read_enable, input, 2, bit0 enables read port 1, bit1 enables read port 2.
REQ-008 Port write_enable, input, 1, write row enable.
REQ-009 Port read_wl1, output, WL_COUNT, read port 1 wordlines, one-hot or zero.
REQ-010 Port read_wl2, output, WL_COUNT, read port 2 wordlines, one-hot or zero.
REQ-011 Port write_wl, output, WL_COUNT, write wordlines, one-hot or zero.

Function
REQ-012 All three outputs SHALL be registered, with one clk cycle latency from the inputs.
REQ-013 read_wl1 SHALL be set to 1 << address_1 when read_enable[0]=1, and to all-zero otherwise.
REQ-014 read_wl2 SHALL be set to 1 << address_2 when read_enable[1]=1, and to all-zero otherwise.
REQ-015 write_wl SHALL be set to 1 << address_1 when write_enable=1, and to all-zero otherwise.
REQ-016 Each output SHALL have at most one bit set in every cycle.
REQ-017 read_enable=2'b11 SHALL assert both read ports at the same time; identical addresses are legal, and both ports then assert the same bit index.
REQ-018 Address 0 SHALL drive bit 0, and address WL_COUNT-1 SHALL drive the MSB, with no wrap-around.
REQ-019 Any enable deassertion SHALL clear the corresponding output on the next edge.
REQ-020 X or Z on an address input while its enable is low SHALL NOT affect the outputs.

Reset
REQ-021 When rst=1 at a rising clk edge, read_wl1, read_wl2 and write_wl SHALL all become all-zero.
REQ-022 rst SHALL take priority over all enables; asserting rst mid-operation SHALL clear active wordlines on that edge.
REQ-023 The first edge after rst deasserts SHALL register the decode of the current inputs.

Configuration
REQ-024 Macro DECODER_2_WR_PRIORITY_EN controls read/write interaction.
- Defined: while write_enable=1, read_wl1 and read_wl2 SHALL be forced all-zero regardless of read_enable; write_wl SHALL be unaffected.
- Undefined: read ports and write port SHALL decode independently, so a simultaneous read and write are both asserted.

Verification
REQ-025 address_1=60, address_2=79, read_enable=2'b10, write_enable=0 -> after 1 clk: read_wl2 has only bit 79 set; read_wl1=0; write_wl=0.
REQ-026 Same addresses, read_enable=2'b00, write_enable=0 -> after 1 clk: all outputs zero.
REQ-027 Same addresses, read_enable=2'b00, write_enable=1 -> after 1 clk: write_wl has only bit 60 set; read outputs zero.
REQ-028 Same addresses, read_enable=2'b01, then 2'b11 (write_enable=0) -> first: read_wl1 has only bit 60 set and read_wl2=0; second: read_wl1 bit 60 and read_wl2 bit 79 both set.
REQ-029 Outputs active, then rst=1 for one edge -> all outputs zero on that edge; address_1=0 then 127 with write_enable=1 -> write_wl bit 0, then bit 127.
REQ-030 read_enable=2'b01 with write_enable=1, address_1=60 -> with the macro: read_wl1=0, write_wl bit 60; without the macro: read_wl1 bit 60 and write_wl bit 60.

Source files
------------

// File: rtl/decoder_2.sv
// decoder_2 -- registered wordline decoder for a 2-read / 1-write array.
//
// Three decode lanes share one implementation:
//   lane 0 : read port 1  (address_1, read_enable[0]) -> read_wl1
//   lane 1 : read port 2  (address_2, read_enable[1]) -> read_wl2
//   lane 2 : write port   (address_1, write_enable)   -> write_wl
// Each lane produces a one-hot (or all-zero) wordline vector that is
// registered, giving one clk of latency from inputs to outputs.
//
// Ports:
//   clk          - single clock, all state on the rising edge
//   rst          - synchronous active-high reset, clears all wordlines
//   address_1    - read port 1 / write row address
//   address_2    - read port 2 row address
//   read_enable  - bit0 enables read port 1, bit1 enables read port 2
//   write_enable - write row enable
//   read_wl1     - read port 1 wordlines (one-hot or zero)
//   read_wl2     - read port 2 wordlines (one-hot or zero)
//   write_wl     - write wordlines (one-hot or zero)
//
// Build option:
//   DECODER_2_WR_PRIORITY_EN - when defined, an active write suppresses
//   both read ports; write_wl is unaffected. When undefined, reads and
//   the write decode independently.

// Single decode lane: one-hot of addr when en is high, else all-zero.
// The address only reaches the output through the enable gate, so an
// unknown address on a disabled lane cannot leak into the wordlines.
module decoder_2_lane #(
  parameter int ADDR_WIDTH = 7,
  parameter int WL_COUNT   = 128
) (
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [WL_COUNT-1:0]   wl
);
  always_comb begin
    wl = '0;
    if (en) wl[addr] = 1'b1;
  end
endmodule

module decoder_2 #(
  parameter int ADDR_WIDTH = 7,
  parameter int WL_COUNT   = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address_1,
  input  logic [ADDR_WIDTH-1:0] address_2,
  input  logic [1:0]            read_enable,
  input  logic                  write_enable,
  output logic [WL_COUNT-1:0]   read_wl1,
  output logic [WL_COUNT-1:0]   read_wl2,
  output logic [WL_COUNT-1:0]   write_wl
);
  localparam int NUM_LANES = 3;

  logic [NUM_LANES-1:0]                 lane_en;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] lane_addr;
  logic [NUM_LANES-1:0][WL_COUNT-1:0]   lane_wl;
  logic [NUM_LANES-1:0][WL_COUNT-1:0]   wl_q;
  logic [1:0]                           rd_en_eff;

  // Write-priority mode masks the read enables before decode, so the
  // suppression costs nothing on the wide wordline side.
`ifdef DECODER_2_WR_PRIORITY_EN
  assign rd_en_eff = read_enable & {2{~write_enable}};
`else
  assign rd_en_eff = read_enable;
`endif

  assign lane_en   = {write_enable, rd_en_eff[1], rd_en_eff[0]};
  assign lane_addr = {address_1, address_2, address_1};

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      decoder_2_lane #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WL_COUNT   (WL_COUNT)
      ) u_lane (
        .en   (lane_en[g]),
        .addr (lane_addr[g]),
        .wl   (lane_wl[g])
      );
    end
  endgenerate

  // Reset overrides every enable on the same edge.
  always_ff @(posedge clk) begin
    if (rst) wl_q <= '0;
    else     wl_q <= lane_wl;
  end

  assign read_wl1 = wl_q[0];
  assign read_wl2 = wl_q[1];
  assign write_wl = wl_q[2];

endmodule

// File: tb/tb_decoder_2.sv
// Self-checking bench for decoder_2: directed vectors followed by
// randomized traffic, checked against a simple arithmetic reference.
module tb_decoder_2;
  localparam int AW = 7;
  localparam int WL = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] address_1, address_2;
  logic [1:0]    read_enable;
  logic          write_enable;
  logic [WL-1:0] read_wl1, read_wl2, write_wl;

  int checks = 0;
  int errors = 0;

  decoder_2 #(.ADDR_WIDTH(AW), .WL_COUNT(WL)) dut (
    .clk          (clk),
    .rst          (rst),
    .address_1    (address_1),
    .address_2    (address_2),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .read_wl1     (read_wl1),
    .read_wl2     (read_wl2),
    .write_wl     (write_wl)
  );

  always #5 clk = ~clk;

`ifdef DECODER_2_WR_PRIORITY_EN
  localparam bit WR_PRIO = 1'b1;
`else
  localparam bit WR_PRIO = 1'b0;
`endif

  // Reference: a wordline vector is 2**addr when enabled, else zero.
  function automatic logic [WL-1:0] wl_of(input bit en, input int addr);
    logic [WL-1:0] one;
    one = WL'(1);
    return en ? (one << addr) : '0;
  endfunction

  task automatic chk(input string tag, input logic [WL-1:0] obs,
                     input logic [WL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one edge, compare all three outputs with the model.
  task automatic step(input string tag, input bit r, input int a1, input int a2,
                      input logic [1:0] re, input bit we);
    logic [WL-1:0] e1, e2, ew;
    bit rd_block;
    rst = r; address_1 = AW'(a1); address_2 = AW'(a2);
    read_enable = re; write_enable = we;
    rd_block = WR_PRIO && we;
    e1 = r ? '0 : wl_of(re[0] && !rd_block, a1);
    e2 = r ? '0 : wl_of(re[1] && !rd_block, a2);
    ew = r ? '0 : wl_of(we, a1);
    @(posedge clk); #1;
    chk({tag, ".rd1"}, read_wl1, e1);
    chk({tag, ".rd2"}, read_wl2, e2);
    chk({tag, ".wr"},  write_wl, ew);
  endtask

  initial begin
    rst = 1'b1; address_1 = '0; address_2 = '0;
    read_enable = 2'b00; write_enable = 1'b0;
    @(posedge clk); #1;

    // Reset beats all enables.
    step("reset_all_en", 1, 5, 9, 2'b11, 1);
    // First edge after reset registers current decode.
    step("post_reset",   0, 3, 4, 2'b11, 0);

    step("rd2_only",     0, 60, 79, 2'b10, 0);
    step("all_off",      0, 60, 79, 2'b00, 0);
    step("wr_only",      0, 60, 79, 2'b00, 1);
    step("rd1_only",     0, 60, 79, 2'b01, 0);
    step("rd_both",      0, 60, 79, 2'b11, 0);
    step("rd_same_addr", 0, 42, 42, 2'b11, 0);
    step("rd_wr_mix",    0, 60, 79, 2'b01, 1);
    step("all_on",       0, 11, 99, 2'b11, 1);
    // Mid-operation reset clears active lines.
    step("mid_reset",    0, 20, 30, 2'b11, 1);
    step("mid_reset_hit",1, 20, 30, 2'b11, 1);
    // Address extremes, no wrap.
    step("wr_addr0",     0, 0, 0, 2'b00, 1);
    step("wr_addr127",   0, 127, 0, 2'b00, 1);
    step("rd_extremes",  0, 0, 127, 2'b11, 0);
    step("deassert",     0, 0, 127, 2'b00, 0);

    // Unknown address on a disabled port must not disturb the outputs.
    rst = 1'b0; read_enable = 2'b01; write_enable = 1'b0;
    address_1 = 7'd17; address_2 = 'x;
    @(posedge clk); #1;
    chk("x_addr2.rd1", read_wl1, wl_of(1, 17));
    chk("x_addr2.rd2", read_wl2, '0);
    chk("x_addr2.wr",  write_wl, '0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 19) == 0),
           int'($urandom_range(0, WL-1)), int'($urandom_range(0, WL-1)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
